// File: rtl/cs_pkg.sv
// Shared types and constants for the colour sequencer and its hue mapper.
package cs_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD    = 2'b00,
        MODE_HUE     = 2'b01,
        MODE_BREATHE = 2'b10
    } mode_e;

    // Hue wheel segments, named by the colour pair each one ramps between.
    typedef enum logic [2:0] {
        SEG_RY = 3'd0,
        SEG_YG = 3'd1,
        SEG_GC = 3'd2,
        SEG_CB = 3'd3,
        SEG_BM = 3'd4,
        SEG_MR = 3'd5
    } seg_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [7:0]  CH_MAX   = 8'hFF;
    localparam logic [23:0] HUE_INIT = {CH_MAX, 8'h00, 8'h00};

    // The unused encoding 2'b11 behaves exactly like HOLD.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_HUE;
            2'b10:   return MODE_BREATHE;
            default: return MODE_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/hue_map.sv
// Combinational hue wheel: segment plus ramp position to a {R,G,B} colour word.
module hue_map
    import cs_pkg::*;
(
    input  seg_e        seg_i,
    input  logic [7:0]  ramp_i,
    output logic [23:0] color_o
);

    logic [7:0] rise;
    logic [7:0] fall;

    assign rise = ramp_i;
    assign fall = CH_MAX - ramp_i;

    always_comb begin
        color_o = HUE_INIT;
        case (seg_i)
            SEG_RY:  color_o = {CH_MAX, rise,   8'h00};
            SEG_YG:  color_o = {fall,   CH_MAX, 8'h00};
            SEG_GC:  color_o = {8'h00,  CH_MAX, rise};
            SEG_CB:  color_o = {8'h00,  fall,   CH_MAX};
            SEG_BM:  color_o = {rise,   8'h00,  CH_MAX};
            SEG_MR:  color_o = {CH_MAX, 8'h00,  fall};
            default: color_o = HUE_INIT;
        endcase
    end

endmodule

// File: rtl/color_sequencer.sv
// Animation sequencer for the RGB mixer: frozen, hue-wheel or breathing colour,
// advanced once every DWELL end-of-period pulses from the mixer.
module color_sequencer
    import cs_pkg::*;
#(
    parameter int STEP  = 1,
    parameter int DWELL = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [1:0]  mode_i,
    input  logic [23:0] base_i,
    input  logic        timeout_i,
    output logic [23:0] color_o,
    output logic        step_o,
    output logic        wrap_o
);

    localparam int              DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [8:0]      STEP9      = 9'(STEP);

    mode_e          mode_q, mode_d, mode_in;
    seg_e           seg_q, seg_d, seg_nx;
    logic [7:0]     ramp_q, ramp_d, ramp_nx;
    logic [7:0]     lvl_q, lvl_d, lvl_nx, lvl_sel;
    dir_e           dir_q, dir_d, dir_nx;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic [23:0]    color_q, color_d;
    logic           step_q, step_d;
    logic           wrap_q, wrap_d;

    logic           mode_chg;
    logic           step_evt;
    logic           dwell_last;
    logic [8:0]     ramp_sum;
    logic [8:0]     lvl_sum;
    logic           hue_roll;
    logic           hue_wrap;
    logic           brt_wrap;
    logic [8:0]     lvl_p1;
    logic [23:0]    hue_color;
    logic [23:0]    brt_color;

    // A mode change outranks a coincident step, so the step is masked here.
    always_comb begin
        mode_in    = decode_mode(mode_i);
        mode_chg   = en_i && (mode_in != mode_q);
        dwell_last = (dwell_q == DWELL_LAST);
        step_evt   = en_i && timeout_i && dwell_last && !mode_chg;
    end

    always_comb begin
        dwell_d = dwell_q;
        if (mode_chg) begin
            dwell_d = '0;
        end else if (en_i && timeout_i) begin
            dwell_d = dwell_last ? '0 : dwell_q + DW'(1);
        end
    end

    always_comb begin
        ramp_sum = {1'b0, ramp_q} + STEP9;
        hue_roll = (ramp_sum >= 9'd255);
        hue_wrap = hue_roll && (seg_q == SEG_MR);
        seg_nx   = seg_q;
        ramp_nx  = ramp_sum[7:0];
        if (hue_roll) begin
            ramp_nx = '0;
            seg_nx  = (seg_q == SEG_MR) ? SEG_RY : seg_e'(seg_q + 3'd1);
        end
    end

    // Breathe level bounces between 0 and 255, clamping at both ends.
    always_comb begin
        lvl_sum  = {1'b0, lvl_q} + STEP9;
        lvl_nx   = lvl_q;
        dir_nx   = dir_q;
        brt_wrap = 1'b0;
        if (dir_q == DIR_UP) begin
            if (lvl_sum >= 9'd255) begin
                lvl_nx = CH_MAX;
                dir_nx = DIR_DOWN;
            end else begin
                lvl_nx = lvl_sum[7:0];
            end
        end else begin
            if ({1'b0, lvl_q} <= STEP9) begin
                lvl_nx   = '0;
                dir_nx   = DIR_UP;
                brt_wrap = 1'b1;
            end else begin
                lvl_nx = lvl_q - STEP9[7:0];
            end
        end
    end

    hue_map u_hue_map (
        .seg_i   (seg_nx),
        .ramp_i  (ramp_nx),
        .color_o (hue_color)
    );

    // Scaling by lvl+1 lets lvl=255 reproduce the base colour exactly.
    assign lvl_sel = mode_chg ? 8'h00 : lvl_nx;
    assign lvl_p1  = {1'b0, lvl_sel} + 9'd1;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_scale
            assign brt_color[gi*8 +: 8] =
                8'((16'(base_i[gi*8 +: 8]) * 16'(lvl_p1)) >> 8);
        end
    endgenerate

    always_comb begin
        mode_d  = mode_q;
        seg_d   = seg_q;
        ramp_d  = ramp_q;
        lvl_d   = lvl_q;
        dir_d   = dir_q;
        color_d = color_q;
        step_d  = step_q;
        wrap_d  = wrap_q;
        if (mode_chg) begin
            mode_d = mode_in;
            seg_d  = SEG_RY;
            ramp_d = '0;
            lvl_d  = '0;
            dir_d  = DIR_UP;
            step_d = 1'b0;
            wrap_d = 1'b0;
            case (mode_in)
                MODE_HUE:     color_d = HUE_INIT;
                MODE_BREATHE: color_d = brt_color;
                default:      color_d = base_i;
            endcase
        end else if (en_i) begin
            step_d = 1'b0;
            wrap_d = 1'b0;
            case (mode_q)
                MODE_HUE: begin
                    if (step_evt) begin
                        seg_d   = seg_nx;
                        ramp_d  = ramp_nx;
                        color_d = hue_color;
                        step_d  = 1'b1;
                        wrap_d  = hue_wrap;
                    end
                end
                MODE_BREATHE: begin
                    if (step_evt) begin
                        lvl_d   = lvl_nx;
                        dir_d   = dir_nx;
                        color_d = brt_color;
                        step_d  = 1'b1;
                        wrap_d  = brt_wrap;
                    end
                end
                default: color_d = base_i;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_HOLD;
            seg_q   <= SEG_RY;
            ramp_q  <= '0;
            lvl_q   <= '0;
            dir_q   <= DIR_UP;
            dwell_q <= '0;
            color_q <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            seg_q   <= seg_d;
            ramp_q  <= ramp_d;
            lvl_q   <= lvl_d;
            dir_q   <= dir_d;
            dwell_q <= dwell_d;
            color_q <= color_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign color_o = color_q;
    assign step_o  = step_q;
    assign wrap_o  = wrap_q;

endmodule
